// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared constants, types and small helpers for the CPU front end.
//
// Contents:
//   PC_STEP           - byte distance between consecutive instructions
//   BUBBLE_INST       - instruction word used for a killed pipeline slot
//   DEFAULT_RESET_PC  - default PC loaded on reset
//   DEFAULT_MEM_WORDS - default instruction-memory depth in 32-bit words
//   pc_sel_e          - which source feeds the PC register this cycle
//   if_id_t           - contents of the IF/ID pipeline register
//   align_word()      - force a byte address onto a word boundary
//   word_in_range()   - check a byte address against the memory depth
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam logic [31:0] PC_STEP           = 32'd4;
  localparam logic [31:0] BUBBLE_INST       = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam int          DEFAULT_MEM_WORDS = 32;

  // Source selected for the next PC value, listed from highest to lowest
  // priority.
  typedef enum logic [1:0] {
    PC_SEL_RESET  = 2'd0,
    PC_SEL_BRANCH = 2'd1,
    PC_SEL_HOLD   = 2'd2,
    PC_SEL_SEQ    = 2'd3
  } pc_sel_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{pc: 32'h0, inst: BUBBLE_INST, valid: 1'b0};

  // Branch targets are byte addresses; the two low bits are dropped so the
  // PC always points at a whole instruction word.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  // True when the word addressed by a byte address exists in a memory of
  // the given depth.
  function automatic logic word_in_range(input logic [31:0] addr,
                                         input logic [31:0] words);
    return (addr >> 2) < words;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register between instruction fetch and decode.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset, clears the register
//   freeze    in   hold the current contents
//   flush     in   load a bubble (beats freeze)
//   pc_in     in   32  PC+4 of the instruction being fetched
//   inst_in   in   32  fetched instruction word
//   valid_in  in   1 = inst_in is a real instruction
//   pc_out    out  32  registered PC+4
//   inst_out  out  32  registered instruction word
//   valid_out out  registered valid flag
// ---------------------------------------------------------------------------
module if_id_reg
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        flush,
  input  logic [31:0] pc_in,
  input  logic [31:0] inst_in,
  input  logic        valid_in,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic        valid_out
);

  if_id_t stage_q;

  // Priority is reset, then flush, then freeze, then a normal load. Flush
  // must win over freeze so a killed slot never lingers while decode stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= IF_ID_BUBBLE;
    end else if (flush) begin
      stage_q <= IF_ID_BUBBLE;
    end else if (freeze) begin
      stage_q <= stage_q;
    end else begin
      stage_q <= '{pc: pc_in, inst: inst_in, valid: valid_in};
    end
  end

  assign pc_out    = stage_q.pc;
  assign inst_out  = stage_q.inst;
  assign valid_out = stage_q.valid;

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction fetch: owns the PC register and next-PC mux, drives the
// instruction memory address and feeds the IF/ID pipeline register.
//
// Parameters:
//   RESET_PC   PC value loaded on reset
//   MEM_WORDS  instruction-memory depth in 32-bit words
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   freeze       in   hazard stall, hold PC and IF/ID
//   branch_taken in   redirect fetch to branch_addr (beats freeze)
//   branch_addr  in   32  byte-address branch target
//   flush        in   kill the next IF/ID contents
//   imem_addr    out  32  byte address to instruction memory (= PC)
//   imem_inst    in   32  instruction word at imem_addr, combinational
//   pc_out       out  32  registered PC+4 of the IF/ID instruction
//   inst_out     out  32  registered instruction word
//   valid_out    out  registered, 1 = inst_out is a real instruction
// ---------------------------------------------------------------------------
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          MEM_WORDS = DEFAULT_MEM_WORDS
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  input  logic        flush,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic        valid_out
);

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);

  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic        fetch_in_range;
  logic [31:0] fetch_inst;
  pc_sel_e     pc_sel;

  // Memory sees the PC register directly so the fetched word is available
  // in the same cycle and lands in IF/ID on the next edge.
  assign imem_addr = pc_q;

  // 32-bit addition wraps naturally, so the last word of the address space
  // is followed by address zero.
  assign pc_plus4      = pc_q + PC_STEP;
  assign branch_target = align_word(branch_addr);

  // Addresses beyond the memory fetch a bubble instead of stalling; the PC
  // keeps advancing so a later branch can still bring fetch back.
  assign fetch_in_range = word_in_range(pc_q, MEM_LIMIT);
  assign fetch_inst     = fetch_in_range ? imem_inst : BUBBLE_INST;

  // Decode the next-PC source. A branch beats freeze because the stalled
  // instruction is on the wrong path anyway. Flush never touches the PC.
  always_comb begin
    pc_sel = PC_SEL_SEQ;
    if (rst) begin
      pc_sel = PC_SEL_RESET;
    end else if (branch_taken) begin
      pc_sel = PC_SEL_BRANCH;
    end else if (freeze) begin
      pc_sel = PC_SEL_HOLD;
    end
  end

  // PC register, loaded from the source chosen above.
  always_ff @(posedge clk) begin
    case (pc_sel)
      PC_SEL_RESET:  pc_q <= RESET_PC;
      PC_SEL_BRANCH: pc_q <= branch_target;
      PC_SEL_HOLD:   pc_q <= pc_q;
      default:       pc_q <= pc_plus4;
    endcase
  end

  // A taken branch also kills the instruction fetched this cycle, since it
  // came from the fall-through path.
  if_id_reg u_if_id (
    .clk       (clk),
    .rst       (rst),
    .freeze    (freeze),
    .flush     (flush | branch_taken),
    .pc_in     (pc_plus4),
    .inst_in   (fetch_inst),
    .valid_in  (fetch_in_range),
    .pc_out    (pc_out),
    .inst_out  (inst_out),
    .valid_out (valid_out)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Directed self-checking bench for fetch_stage with a 32-word instruction
// memory model. Word i of memory holds 32'hC0DE_0000 + i; addresses beyond
// the memory return 32'hDEAD_BEEF so the design must mask them itself.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        flush;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        valid_out;

  int assertCount;
  int failCount;

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .MEM_WORDS (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .flush        (flush),
    .imem_addr    (imem_addr),
    .imem_inst    (imem_inst),
    .pc_out       (pc_out),
    .inst_out     (inst_out),
    .valid_out    (valid_out)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational instruction memory; out-of-range reads return junk.
  always_comb begin
    imem_inst = 32'hDEAD_BEEF;
    if (imem_addr[31:2] < 30'd32) begin
      imem_inst = 32'hC0DE_0000 + {2'b00, imem_addr[31:2]};
    end
  end

  // Drive one cycle's inputs, advance past the rising edge, and settle.
  task automatic applyStimulus(input logic rstV, input logic frzV,
                               input logic brV, input logic [31:0] baddrV,
                               input logic flV);
    rst          = rstV;
    freeze       = frzV;
    branch_taken = brV;
    branch_addr  = baddrV;
    flush        = flV;
    @(posedge clk);
    #1;
  endtask

  // Compare every observable output against hand-computed values.
  task automatic checkOutput(input string tag, input logic [31:0] expAddr,
                             input logic [31:0] expPc, input logic [31:0] expInst,
                             input logic expValid);
    assertCount++;
    assert (imem_addr === expAddr) else begin
      failCount++;
      $error("[TB] FAIL %s imem_addr got %h expected %h", tag, imem_addr, expAddr);
    end
    assertCount++;
    assert (pc_out === expPc) else begin
      failCount++;
      $error("[TB] FAIL %s pc_out got %h expected %h", tag, pc_out, expPc);
    end
    assertCount++;
    assert (inst_out === expInst) else begin
      failCount++;
      $error("[TB] FAIL %s inst_out got %h expected %h", tag, inst_out, expInst);
    end
    assertCount++;
    assert (valid_out === expValid) else begin
      failCount++;
      $error("[TB] FAIL %s valid_out got %b expected %b", tag, valid_out, expValid);
    end
  endtask

  initial begin
    assertCount  = 0;
    failCount    = 0;
    rst          = 1'b1;
    freeze       = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = 32'h0;
    flush        = 1'b0;

    // Reset held for two cycles.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("reset", 32'h0, 32'h0, 32'h0, 1'b0);

    // Sequential fetch from address 0.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("seq1", 32'h04, 32'h04, 32'hC0DE_0000, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("seq2", 32'h08, 32'h08, 32'hC0DE_0001, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("seq3", 32'h0C, 32'h0C, 32'hC0DE_0002, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("seq4", 32'h10, 32'h10, 32'hC0DE_0003, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("seq5", 32'h14, 32'h14, 32'hC0DE_0004, 1'b1);

    // Freeze at PC=20, then reset arrives while still frozen.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("frz_pc20", 32'h14, 32'h14, 32'hC0DE_0004, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("mid_reset", 32'h0, 32'h0, 32'h0, 1'b0);

    // Refill up to PC=8, then freeze for three cycles.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("refill1", 32'h04, 32'h04, 32'hC0DE_0000, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("refill2", 32'h08, 32'h08, 32'hC0DE_0001, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      checkOutput("freeze_hold", 32'h08, 32'h08, 32'hC0DE_0001, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("freeze_release", 32'h0C, 32'h0C, 32'hC0DE_0002, 1'b1);

    // Branch with freeze at PC=12; unaligned target 0x2E lands on 0x2C.
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_002E, 1'b0);
    checkOutput("branch_freeze", 32'h2C, 32'h0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("after_branch", 32'h30, 32'h30, 32'hC0DE_000B, 1'b1);

    // Flush alone kills IF/ID but the PC keeps stepping.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("flush", 32'h34, 32'h0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("after_flush", 32'h38, 32'h38, 32'hC0DE_000D, 1'b1);

    // Last in-range word, then past the end of memory.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_007C, 1'b0);
    checkOutput("branch_last", 32'h7C, 32'h0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("last_word", 32'h80, 32'h80, 32'hC0DE_001F, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("out_of_range1", 32'h84, 32'h84, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("out_of_range2", 32'h88, 32'h88, 32'h0, 1'b0);

    // Wrap from the top of the address space back to zero.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    checkOutput("branch_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("wrap", 32'h0, 32'h0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("after_wrap", 32'h04, 32'h04, 32'hC0DE_0000, 1'b1);

    // Flush together with freeze: bubble wins, PC still holds.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("flush_freeze", 32'h04, 32'h0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("after_flush_freeze", 32'h08, 32'h08, 32'hC0DE_0001, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
